// File: rtl/cr_xp10_decomp_lz77_pfx_ld_pkg.sv
// Shared types and constants for the XP10 decompressor LZ77 prefix loader.
package cr_xp10_decompPKG;

  localparam int CR_LZ_PRFX_SZ = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2
  } pfx_ld_state_e;

  typedef struct packed {
    logic       pfx_en;
    logic [1:0] pfx_sel;
    logic       pfx_load;
    logic [6:0] pfx_len;
  } pfx_desc_t;

endpackage

// File: rtl/cr_xp10_decomp_lz77_pfx_ld_wrmux.sv
// Registered one-hot fan-out of one prefix write into the three prefix RAM
// write ports, plus the registered prefix in_use flags.
module cr_xp10_decomp_lz77_pfx_ld_wrmux
  import cr_xp10_decompPKG::*;
#(
  parameter int DATA_W = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [1:0]             wr_sel,
  input  logic [5:0]             wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   use_en,
  input  logic [1:0]             use_sel,
  output logic [2:0]             pfx_wr,
  output logic [2:0][5:0]        pfx_waddr,
  output logic [2:0][DATA_W-1:0] pfx_wdata,
  output logic [2:0]             pfx_in_use
);

  logic [2:0]             wr_q, wr_d;
  logic [2:0][5:0]        waddr_q, waddr_d;
  logic [2:0][DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]             in_use_q, in_use_d;

  always_comb begin
    wr_d     = '0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    in_use_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (wr_en && (wr_sel == 2'(i))) begin
        wr_d[i]    = 1'b1;
        waddr_d[i] = wr_addr;
        wdata_d[i] = wr_data;
      end
      // Decoding the slot compare keeps in_use one-hot even for a bad select.
      if (use_en && (use_sel == 2'(i))) in_use_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q     <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      in_use_q <= '0;
    end else begin
      wr_q     <= wr_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      in_use_q <= in_use_d;
    end
  end

  assign pfx_wr     = wr_q;
  assign pfx_waddr  = waddr_q;
  assign pfx_wdata  = wdata_q;
  assign pfx_in_use = in_use_q;

endmodule

// File: rtl/cr_xp10_decomp_lz77_pfx_ld.sv
// LZ77 prefix/user-data loader: loads prefix RAMs from a per-frame descriptor,
// holds the chosen prefix in use until eof, and streams user data into the HB.
module cr_xp10_decomp_lz77_pfx_ld
  import cr_xp10_decompPKG::*;
#(
  parameter int DATA_W    = 128,
  parameter int PFX_DEPTH = CR_LZ_PRFX_SZ,
  parameter int HB_AW     = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic              desc_pfx_en,
  input  logic [1:0]        desc_pfx_sel,
  input  logic              desc_pfx_load,
  input  logic [6:0]        desc_pfx_len,
  input  logic              pld_valid,
  output logic              pld_ready,
  input  logic [DATA_W-1:0] pld_data,
  input  logic              pld_last,
  input  logic              usr_valid,
  output logic              usr_ready,
  input  logic [DATA_W-1:0] usr_data,
  input  logic              ag_ep_hb_wr,
  input  logic              ag_hb_eof,
  output logic              pl_hb_pfx0_pld_wr,
  output logic [5:0]        pl_hb_pfx0_pld_waddr,
  output logic [DATA_W-1:0] pl_hb_pfx0_pld_wdata,
  output logic              pl_hb_pfx1_pld_wr,
  output logic [5:0]        pl_hb_pfx1_pld_waddr,
  output logic [DATA_W-1:0] pl_hb_pfx1_pld_wdata,
  output logic              pl_hb_pfx2_pld_wr,
  output logic [5:0]        pl_hb_pfx2_pld_waddr,
  output logic [DATA_W-1:0] pl_hb_pfx2_pld_wdata,
  output logic              pl_hb_pfx0_in_use,
  output logic              pl_hb_pfx1_in_use,
  output logic              pl_hb_pfx2_in_use,
  output logic              pl_hb_usr_wr,
  output logic [HB_AW-1:0]  pl_hb_usr_waddr,
  output logic [DATA_W-1:0] pl_hb_usr_wdata,
  output logic              pfx_len_err,
  output logic              pfx_abort_err,
  output logic              desc_err
);

  localparam logic [HB_AW-1:0] USR_BASE = HB_AW'(PFX_DEPTH);

  pfx_ld_state_e     state_q, state_d;
  pfx_desc_t         desc_q, desc_d;
  logic [6:0]        bcnt_q, bcnt_d;
  logic [HB_AW-1:0]  ucnt_q, ucnt_d;
  logic              usr_wr_q, usr_wr_d;
  logic [HB_AW-1:0]  usr_waddr_q, usr_waddr_d;
  logic [DATA_W-1:0] usr_wdata_q, usr_wdata_d;
  logic              len_err_q, len_err_d;
  logic              abort_err_q, abort_err_d;
  logic              desc_err_q, desc_err_d;
  logic              pld_acc, usr_acc, len_hit, use_en;

  always_comb begin
    state_d     = state_q;
    desc_d      = desc_q;
    bcnt_d      = bcnt_q;
    ucnt_d      = ucnt_q;
    len_err_d   = 1'b0;
    abort_err_d = 1'b0;
    desc_err_d  = 1'b0;
    desc_ready  = (state_q == IDLE);
    pld_ready   = (state_q == LOAD) && desc_q.pfx_load;
    usr_ready   = (state_q == ARMED) && !ag_ep_hb_wr;
    pld_acc     = pld_valid && pld_ready;
    usr_acc     = usr_valid && usr_ready;
    len_hit     = (bcnt_q + 7'd1) >= desc_q.pfx_len;
    usr_wr_d    = usr_acc;
    usr_waddr_d = usr_acc ? ucnt_q : usr_waddr_q;
    usr_wdata_d = usr_acc ? usr_data : usr_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (desc_valid) begin
          desc_d = '{pfx_en: desc_pfx_en, pfx_sel: desc_pfx_sel,
                     pfx_load: desc_pfx_load, pfx_len: desc_pfx_len};
          bcnt_d = '0;
          if (desc_pfx_en && (desc_pfx_sel == 2'd3)) begin
            desc_err_d    = 1'b1;
            desc_d.pfx_en = 1'b0;
            state_d       = ARMED;
          end else if (desc_pfx_en && desc_pfx_load) begin
            state_d = LOAD;
          end else begin
            state_d = ARMED;
          end
        end
      end
      LOAD: begin
        if (pld_acc) begin
          bcnt_d = bcnt_q + 7'd1;
          // Whichever of pld_last / length reached comes first ends the load.
          if (pld_last || len_hit) begin
            state_d   = ARMED;
            len_err_d = pld_last ^ len_hit;
          end
        end
      end
      ARMED: begin
        if (usr_acc) ucnt_d = (ucnt_q == '1) ? USR_BASE : ucnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // End of frame overrides everything; a same-cycle user beat keeps its address.
    if (ag_hb_eof) begin
      state_d     = IDLE;
      ucnt_d      = USR_BASE;
      len_err_d   = 1'b0;
      desc_err_d  = 1'b0;
      abort_err_d = (state_q == LOAD);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      desc_q      <= '0;
      bcnt_q      <= '0;
      ucnt_q      <= USR_BASE;
      usr_wr_q    <= 1'b0;
      usr_waddr_q <= '0;
      usr_wdata_q <= '0;
      len_err_q   <= 1'b0;
      abort_err_q <= 1'b0;
      desc_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      desc_q      <= desc_d;
      bcnt_q      <= bcnt_d;
      ucnt_q      <= ucnt_d;
      usr_wr_q    <= usr_wr_d;
      usr_waddr_q <= usr_waddr_d;
      usr_wdata_q <= usr_wdata_d;
      len_err_q   <= len_err_d;
      abort_err_q <= abort_err_d;
      desc_err_q  <= desc_err_d;
    end
  end

  assign use_en = (state_q == ARMED) && desc_q.pfx_en && !ag_hb_eof;

  logic [2:0]             pfx_wr;
  logic [2:0][5:0]        pfx_waddr;
  logic [2:0][DATA_W-1:0] pfx_wdata;
  logic [2:0]             pfx_in_use;

  cr_xp10_decomp_lz77_pfx_ld_wrmux #(.DATA_W(DATA_W)) u_wrmux (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (pld_acc),
    .wr_sel     (desc_q.pfx_sel),
    .wr_addr    (bcnt_q[5:0]),
    .wr_data    (pld_data),
    .use_en     (use_en),
    .use_sel    (desc_q.pfx_sel),
    .pfx_wr     (pfx_wr),
    .pfx_waddr  (pfx_waddr),
    .pfx_wdata  (pfx_wdata),
    .pfx_in_use (pfx_in_use)
  );

  assign pl_hb_pfx0_pld_wr    = pfx_wr[0];
  assign pl_hb_pfx0_pld_waddr = pfx_waddr[0];
  assign pl_hb_pfx0_pld_wdata = pfx_wdata[0];
  assign pl_hb_pfx1_pld_wr    = pfx_wr[1];
  assign pl_hb_pfx1_pld_waddr = pfx_waddr[1];
  assign pl_hb_pfx1_pld_wdata = pfx_wdata[1];
  assign pl_hb_pfx2_pld_wr    = pfx_wr[2];
  assign pl_hb_pfx2_pld_waddr = pfx_waddr[2];
  assign pl_hb_pfx2_pld_wdata = pfx_wdata[2];
  assign pl_hb_pfx0_in_use    = pfx_in_use[0];
  assign pl_hb_pfx1_in_use    = pfx_in_use[1];
  assign pl_hb_pfx2_in_use    = pfx_in_use[2];
  assign pl_hb_usr_wr         = usr_wr_q;
  assign pl_hb_usr_waddr      = usr_waddr_q;
  assign pl_hb_usr_wdata      = usr_wdata_q;
  assign pfx_len_err          = len_err_q;
  assign pfx_abort_err        = abort_err_q;
  assign desc_err             = desc_err_q;

endmodule

// File: tb/tb_cr_xp10_decomp_lz77_pfx_ld.sv
// Bench for the LZ77 prefix loader: directed scenarios plus random traffic,
// all checked against a frame-level behavioural model.
module tb_cr_xp10_decomp_lz77_pfx_ld;
  localparam int DATA_W = 128;
  localparam int HB_AW  = 12;
  localparam int BASE   = 64;
  localparam int SPAN   = 4096 - 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic desc_valid, desc_pfx_en, desc_pfx_load;
  logic [1:0] desc_pfx_sel;
  logic [6:0] desc_pfx_len;
  logic pld_valid, pld_last, usr_valid, ag_ep_hb_wr, ag_hb_eof;
  logic [DATA_W-1:0] pld_data, usr_data;
  logic desc_ready, pld_ready, usr_ready;
  logic pfx0_wr, pfx1_wr, pfx2_wr, pfx0_iu, pfx1_iu, pfx2_iu;
  logic [5:0] pfx0_wa, pfx1_wa, pfx2_wa;
  logic [DATA_W-1:0] pfx0_wd, pfx1_wd, pfx2_wd, usr_wd;
  logic usr_wr, len_err, abort_err, d_err;
  logic [HB_AW-1:0] usr_wa;

  cr_xp10_decomp_lz77_pfx_ld #(.DATA_W(DATA_W), .PFX_DEPTH(64), .HB_AW(HB_AW)) dut (
    .clk(clk), .rst(rst),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_pfx_en(desc_pfx_en),
    .desc_pfx_sel(desc_pfx_sel), .desc_pfx_load(desc_pfx_load), .desc_pfx_len(desc_pfx_len),
    .pld_valid(pld_valid), .pld_ready(pld_ready), .pld_data(pld_data), .pld_last(pld_last),
    .usr_valid(usr_valid), .usr_ready(usr_ready), .usr_data(usr_data),
    .ag_ep_hb_wr(ag_ep_hb_wr), .ag_hb_eof(ag_hb_eof),
    .pl_hb_pfx0_pld_wr(pfx0_wr), .pl_hb_pfx0_pld_waddr(pfx0_wa), .pl_hb_pfx0_pld_wdata(pfx0_wd),
    .pl_hb_pfx1_pld_wr(pfx1_wr), .pl_hb_pfx1_pld_waddr(pfx1_wa), .pl_hb_pfx1_pld_wdata(pfx1_wd),
    .pl_hb_pfx2_pld_wr(pfx2_wr), .pl_hb_pfx2_pld_waddr(pfx2_wa), .pl_hb_pfx2_pld_wdata(pfx2_wd),
    .pl_hb_pfx0_in_use(pfx0_iu), .pl_hb_pfx1_in_use(pfx1_iu), .pl_hb_pfx2_in_use(pfx2_iu),
    .pl_hb_usr_wr(usr_wr), .pl_hb_usr_waddr(usr_wa), .pl_hb_usr_wdata(usr_wd),
    .pfx_len_err(len_err), .pfx_abort_err(abort_err), .desc_err(d_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: phase 0 = waiting for descriptor, 1 = loading, 2 = frame running.
  int ph, m_sel, m_len, m_loaded, m_slot, m_usr_n;
  logic [2:0] e_pwr, e_inuse;
  logic [5:0] e_pwa [3];
  logic [DATA_W-1:0] e_pwd [3];
  logic e_uwr, e_lerr, e_aerr, e_derr;
  logic [HB_AW-1:0] e_uwa;
  logic [DATA_W-1:0] e_uwd;

  function automatic logic [DATA_W-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic clr();
    desc_valid = 0; desc_pfx_en = 0; desc_pfx_sel = 0; desc_pfx_load = 0; desc_pfx_len = 0;
    pld_valid = 0; pld_last = 0; pld_data = '0; usr_valid = 0; usr_data = '0;
    ag_ep_hb_wr = 0; ag_hb_eof = 0;
  endtask

  task automatic step();
    bit dacc, pacc, uacc;
    #1;
    if (!rst) begin
      chk("desc_ready", desc_ready, ph == 0);
      chk("pld_ready", pld_ready, ph == 1);
      chk("usr_ready", usr_ready, (ph == 2) && !ag_ep_hb_wr);
    end
    dacc = desc_valid && (ph == 0);
    pacc = pld_valid && (ph == 1);
    uacc = usr_valid && (ph == 2) && !ag_ep_hb_wr;
    if (rst) begin
      ph = 0; m_usr_n = 0; m_slot = -1; m_loaded = 0;
      e_pwr = 0; e_inuse = 0; e_uwr = 0; e_uwa = 0; e_uwd = 0;
      e_lerr = 0; e_aerr = 0; e_derr = 0;
      for (int s = 0; s < 3; s++) begin e_pwa[s] = 0; e_pwd[s] = 0; end
    end else begin
      e_pwr = 0;
      if (pacc) begin
        e_pwr[m_sel] = 1'b1; e_pwa[m_sel] = 6'(m_loaded); e_pwd[m_sel] = pld_data;
      end
      e_uwr = uacc;
      if (uacc) begin
        e_uwa = HB_AW'(BASE + (m_usr_n % SPAN)); e_uwd = usr_data;
      end
      e_inuse = (ph == 2 && m_slot >= 0 && !ag_hb_eof) ? 3'(1 << m_slot) : 3'd0;
      e_lerr = 0; e_aerr = 0; e_derr = 0;
      if (ag_hb_eof) begin
        e_aerr = (ph == 1); ph = 0; m_usr_n = 0;
      end else if (ph == 0) begin
        if (dacc) begin
          if (desc_pfx_en && desc_pfx_sel == 3) begin
            e_derr = 1; ph = 2; m_slot = -1;
          end else if (desc_pfx_en && desc_pfx_load) begin
            ph = 1; m_sel = desc_pfx_sel; m_len = desc_pfx_len; m_loaded = 0;
          end else begin
            ph = 2; m_slot = desc_pfx_en ? int'(desc_pfx_sel) : -1;
          end
        end
      end else if (ph == 1) begin
        if (pacc) begin
          m_loaded++;
          if (pld_last || m_loaded == m_len) begin
            e_lerr = !(pld_last && m_loaded == m_len); ph = 2; m_slot = m_sel;
          end
        end
      end else begin
        if (uacc) m_usr_n++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("pfx_wr", {pfx2_wr, pfx1_wr, pfx0_wr}, e_pwr);
    chk("pfx0_waddr", pfx0_wa, e_pwa[0]);
    chk("pfx1_waddr", pfx1_wa, e_pwa[1]);
    chk("pfx2_waddr", pfx2_wa, e_pwa[2]);
    chk("pfx0_wdata", pfx0_wd, e_pwd[0]);
    chk("pfx1_wdata", pfx1_wd, e_pwd[1]);
    chk("pfx2_wdata", pfx2_wd, e_pwd[2]);
    chk("in_use", {pfx2_iu, pfx1_iu, pfx0_iu}, e_inuse);
    chk("usr_wr", usr_wr, e_uwr);
    chk("usr_waddr", usr_wa, e_uwa);
    chk("usr_wdata", usr_wd, e_uwd);
    chk("len_err", len_err, e_lerr);
    chk("abort_err", abort_err, e_aerr);
    chk("desc_err", d_err, e_derr);
  endtask

  task automatic desc(input bit en, input int sel, input bit ld, input int len);
    clr();
    desc_valid = 1; desc_pfx_en = en; desc_pfx_sel = 2'(sel);
    desc_pfx_load = ld; desc_pfx_len = 7'(len);
    step();
  endtask

  task automatic eof();
    clr(); ag_hb_eof = 1; step();
  endtask

  initial begin
    clr();
    rst = 1;
    step();
    step();
    chk("rst_desc_ready", desc_ready, 1'b1);
    chk("rst_usr_ready", usr_ready, 1'b0);
    rst = 0;

    // Four-beat load into slot 1
    desc(1, 1, 1, 4);
    for (int i = 0; i < 4; i++) begin
      clr(); pld_valid = 1; pld_data = rnd128(); pld_last = (i == 3);
      step();
      chk("t1_wr", pfx1_wr, 1'b1);
      chk("t1_addr", pfx1_wa, 6'(i));
      chk("t1_iu_low", pfx1_iu, 1'b0);
    end
    clr(); step();
    chk("t1_iu_high", pfx1_iu, 1'b1);

    // User beats with one AG collision
    for (int i = 0; i < 4; i++) begin
      clr(); usr_valid = 1; usr_data = rnd128(); ag_ep_hb_wr = (i == 1);
      step();
    end
    clr(); step();
    eof();
    chk("t2_iu_clr", {pfx2_iu, pfx1_iu, pfx0_iu}, 3'd0);

    // Address wrap at the top of the history buffer
    desc(0, 0, 0, 1);
    for (int i = 0; i < SPAN - 1; i++) begin
      clr(); usr_valid = 1; usr_data = rnd128(); step();
    end
    clr(); usr_valid = 1; usr_data = rnd128(); step();
    chk("wrap_hi", usr_wa, 12'd4095);
    clr(); usr_valid = 1; usr_data = rnd128(); step();
    chk("wrap_lo", usr_wa, 12'd64);
    eof();

    // Early pld_last: len 8, last on beat 5
    desc(1, 2, 1, 8);
    for (int i = 0; i < 5; i++) begin
      clr(); pld_valid = 1; pld_data = rnd128(); pld_last = (i == 4); step();
    end
    chk("t4_len_err", len_err, 1'b1);
    chk("t4_last_addr", pfx2_wa, 6'd4);
    clr(); step();
    chk("t4_iu", pfx2_iu, 1'b1);
    eof();

    // eof abandons a load
    desc(1, 0, 1, 6);
    for (int i = 0; i < 2; i++) begin
      clr(); pld_valid = 1; pld_data = rnd128(); step();
    end
    eof();
    chk("t5_abort", abort_err, 1'b1);
    chk("t5_ready", desc_ready, 1'b1);
    clr(); step();
    chk("t5_iu", {pfx2_iu, pfx1_iu, pfx0_iu}, 3'd0);

    // Illegal select
    desc(1, 3, 1, 4);
    chk("t6_derr", d_err, 1'b1);
    clr(); usr_valid = 1; usr_data = rnd128(); step();
    chk("t6_addr", usr_wa, 12'd64);
    chk("t6_iu", {pfx2_iu, pfx1_iu, pfx0_iu}, 3'd0);
    eof();

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      clr();
      rst = ($urandom_range(0, 599) == 0);
      desc_valid = ($urandom_range(0, 2) == 0);
      desc_pfx_en = ($urandom_range(0, 3) != 0);
      desc_pfx_sel = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      desc_pfx_load = ($urandom_range(0, 2) != 0);
      desc_pfx_len = ($urandom_range(0, 15) == 0) ? 7'd64 : 7'($urandom_range(1, 6));
      pld_valid = ($urandom_range(0, 3) != 0);
      pld_data = rnd128();
      pld_last = (ph == 1 && m_loaded + 1 >= m_len) ? ($urandom_range(0, 3) != 0)
                                                    : ($urandom_range(0, 7) == 0);
      usr_valid = $urandom_range(0, 1);
      usr_data = rnd128();
      ag_ep_hb_wr = ($urandom_range(0, 3) == 0);
      ag_hb_eof = (ph == 2) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 59) == 0);
      step();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
